// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle Hack-style core: FSM states, instruction
// field positions and ALU control bit indices.
package cpu_mc_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      WB     = 3'd4
   } state_e;

   // C-instruction field positions (low bits are width independent)
   localparam int JMP_LO  = 0;
   localparam int JMP_HI  = 2;
   localparam int DEST_M  = 3;
   localparam int DEST_D  = 4;
   localparam int DEST_A  = 5;
   localparam int COMP_LO = 6;
   localparam int COMP_HI = 11;
   localparam int ABIT    = 12;

   // Bit indices inside the 6-bit comp field
   localparam int ALU_NO = 0;
   localparam int ALU_F  = 1;
   localparam int ALU_NY = 2;
   localparam int ALU_ZY = 3;
   localparam int ALU_NX = 4;
   localparam int ALU_ZX = 5;

   // Bit indices inside the 3-bit jump field
   localparam int J_GT = 0;
   localparam int J_EQ = 1;
   localparam int J_LT = 2;

   // The instruction-type bit is the MSB, so it moves with the word width
   function automatic int type_bit(input int w);
      return w - 1;
   endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational Hack ALU with zero/negative flags and jump-condition evaluation.
module cpu_mc_alu
   import cpu_mc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic [5:0]   comp_i,
   input  logic [2:0]   jmp_i,
   output logic [W-1:0] result_o,
   output logic         zr_o,
   output logic         ng_o,
   output logic         taken_o
);

   logic [W-1:0] x_z, x_n, y_z, y_n, f_out;

   always_comb begin
      x_z      = comp_i[ALU_ZX] ? '0 : x_i;
      x_n      = comp_i[ALU_NX] ? ~x_z : x_z;
      y_z      = comp_i[ALU_ZY] ? '0 : y_i;
      y_n      = comp_i[ALU_NY] ? ~y_z : y_z;
      f_out    = comp_i[ALU_F] ? (x_n + y_n) : (x_n & y_n);
      result_o = comp_i[ALU_NO] ? ~f_out : f_out;
      zr_o     = (result_o == '0);
      ng_o     = result_o[W-1];
      taken_o  = (jmp_i[J_LT] & ng_o) | (jmp_i[J_EQ] & zr_o) | (jmp_i[J_GT] & ~zr_o & ~ng_o);
   end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle Hack-style core with req/ack instruction and data ports.
// Optional retired-instruction counter enabled by defining CPU_MC_PERF_EN.
module cpu_mc
   import cpu_mc_pkg::*;
#(
   parameter int          W        = 16,
   parameter int          AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [W-1:0]  imem_rdata,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [W-1:0]  dmem_wdata,
   input  logic          dmem_ack,
   input  logic [W-1:0]  dmem_rdata,
   output logic [AW-1:0] pc,
   output logic [W-1:0]  out
`ifdef CPU_MC_PERF_EN
   ,
   output logic [31:0]   retired
`endif
);

   localparam int TYPE = type_bit(W);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [W-1:0]  a_q, a_d, d_q, d_d, ir_q, ir_d, m_q, m_d, out_q, out_d;
   logic          fetch_busy_q, fetch_busy_d;

   logic [W-1:0]  alu_result;
   logic          alu_zr, alu_ng, alu_taken;
   logic          is_c, dest_m;

   assign is_c   = ir_q[TYPE];
   assign dest_m = is_c & ir_q[DEST_M];

   cpu_mc_alu #(.W(W)) u_alu (
      .x_i      (d_q),
      .y_i      (ir_q[ABIT] ? m_q : a_q),
      .comp_i   (ir_q[COMP_HI:COMP_LO]),
      .jmp_i    (ir_q[JMP_HI:JMP_LO]),
      .result_o (alu_result),
      .zr_o     (alu_zr),
      .ng_o     (alu_ng),
      .taken_o  (alu_taken)
   );

   // A fetch already on the bus stays requested even if run drops mid-wait
   assign imem_req   = ~reset & (state_q == FETCH) & (run | fetch_busy_q);
   assign imem_addr  = pc_q;
   assign dmem_req   = ~reset & ((state_q == MEM_RD) | (state_q == MEM_WR));
   assign dmem_we    = (state_q == MEM_WR);
   assign dmem_addr  = a_q[AW-1:0];
   assign dmem_wdata = alu_result;
   assign pc         = pc_q;
   assign out        = out_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      a_d          = a_q;
      d_d          = d_q;
      ir_d         = ir_q;
      m_d          = m_q;
      out_d        = out_q;
      fetch_busy_d = 1'b0;
      case (state_q)
         FETCH: begin
            if (imem_req && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = DECODE;
            end else begin
               fetch_busy_d = imem_req;
            end
         end
         DECODE: begin
            if (!is_c)           state_d = WB;
            else if (ir_q[ABIT]) state_d = MEM_RD;
            else if (dest_m)     state_d = MEM_WR;
            else                 state_d = WB;
         end
         MEM_RD: begin
            if (dmem_ack) begin
               m_d     = dmem_rdata;
               state_d = dest_m ? MEM_WR : WB;
            end
         end
         MEM_WR: begin
            if (dmem_ack) state_d = WB;
         end
         WB: begin
            state_d = FETCH;
            if (!is_c) begin
               a_d  = {1'b0, ir_q[W-2:0]};
               pc_d = pc_q + AW'(1);
            end else begin
               out_d = alu_result;
               // Jump target is the A value from before this writeback
               pc_d  = alu_taken ? a_q[AW-1:0] : pc_q + AW'(1);
               if (ir_q[DEST_A]) a_d = alu_result;
               if (ir_q[DEST_D]) d_d = alu_result;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         a_q          <= '0;
         d_q          <= '0;
         ir_q         <= '0;
         m_q          <= '0;
         out_q        <= '0;
         fetch_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         a_q          <= a_d;
         d_q          <= d_d;
         ir_q         <= ir_d;
         m_q          <= m_d;
         out_q        <= out_d;
         fetch_busy_q <= fetch_busy_d;
      end
   end

`ifdef CPU_MC_PERF_EN
   logic [31:0] retired_q, retired_d;

   assign retired_d = retired_q + ((state_q == WB) ? 32'd1 : 32'd0);
   assign retired   = retired_q;

   always_ff @(posedge clk) begin
      if (reset) retired_q <= '0;
      else       retired_q <= retired_d;
   end
`endif

endmodule
